// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU sitting between the A/B operand registers and
// the Z (HI/LO) register pair. Single-cycle logic/arith/shift ops, plus an
// iterative radix-2 Booth multiply and a restoring signed divide.
//
// Handshake: start is sampled only in IDLE; busy is high while an iterative
// op is in flight (MUL/DIV/FIX); done pulses for one cycle in FIN, and
// result/div_by_zero are stable from that cycle until the next accepted
// start writes them again.
//
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-low reset
//   start        begin operation (IDLE only)
//   opcode[4:0]  operation select
//   inc_pc       overrides opcode at start: result = A+1
//   a_in, b_in   operands (latched on an accepted start)
//   busy         iterative op in progress
//   done         one-cycle result-valid pulse
//   result       {hi, lo}
//   div_by_zero  divide by zero occurred on the last divide
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [4:0]         opcode,
   input  logic               inc_pc,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FIN} state_e;

   state_e               state_q, state_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   // acc_hi: Booth partial product (one guard bit) / divide remainder.
   // acc_lo: multiplier being shifted out / dividend-quotient register.
   logic [WIDTH:0]       acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
   logic                 acc_b0_q, acc_b0_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 dbz_q, dbz_d;

   // ---------------- single-cycle ops (from the operands at start) -------
   logic [SHW-1:0]       amt;
   logic [2*WIDTH-1:0]   rot_r, rot_l;
   logic [WIDTH-1:0]     alu_lo;

   assign amt   = b_in[SHW-1:0];
   assign rot_r = {a_in, a_in} >> amt;
   assign rot_l = {a_in, a_in} << amt;

   always_comb begin
      alu_lo = '0;
      case (opcode)
         OP_AND:  alu_lo = a_in & b_in;
         OP_OR:   alu_lo = a_in | b_in;
         OP_ADD:  alu_lo = a_in + b_in;
         OP_SUB:  alu_lo = a_in - b_in;
         OP_SHR:  alu_lo = a_in >> amt;
         OP_SHRA: alu_lo = $signed(a_in) >>> amt;
         OP_SHL:  alu_lo = a_in << amt;
         OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
         OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
         OP_NEG:  alu_lo = '0 - b_in;
         OP_NOT:  alu_lo = ~b_in;
         default: alu_lo = '0;
      endcase
   end

   // ---------------- Booth step ------------------------------------------
   // The guard bit on acc_hi keeps "acc - M" exact when M is most-negative.
   logic [WIDTH:0]       m_ext, booth_sum, booth_hi;
   logic [WIDTH-1:0]     booth_lo;

   assign m_ext = {a_q[WIDTH-1], a_q};

   always_comb begin
      case ({acc_lo_q[0], acc_b0_q})
         2'b01:   booth_sum = acc_hi_q + m_ext;
         2'b10:   booth_sum = acc_hi_q - m_ext;
         default: booth_sum = acc_hi_q;
      endcase
   end

   assign booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
   assign booth_lo = {booth_sum[0], acc_lo_q[WIDTH-1:1]};

   // ---------------- restoring divide step -------------------------------
   // Remainder < divisor <= 2^(WIDTH-1), so the shifted remainder never
   // exceeds WIDTH bits and div_diff[WIDTH] is a true sign bit.
   logic [WIDTH-1:0]     a_mag, d_mag;
   logic [WIDTH:0]       div_shift, div_diff;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   assign a_mag     = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
   assign d_mag     = b_q[WIDTH-1] ? ('0 - b_q) : b_q;
   assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, d_mag};
   assign quo_fix   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ('0 - acc_lo_q) : acc_lo_q;
   assign rem_fix   = a_q[WIDTH-1] ? ('0 - acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];

   // ---------------- FSM next state --------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      acc_b0_d = acc_b0_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = a_in;
               b_d   = b_in;
               cnt_d = (SHW+1)'(WIDTH);
               dbz_d = 1'b0;
               if (inc_pc) begin
                  result_d = {{WIDTH{1'b0}}, a_in + WIDTH'(1)};
                  state_d  = S_FIN;
               end else begin
                  case (opcode)
                     OP_MUL: begin
                        acc_hi_d = '0;
                        acc_lo_d = b_in;
                        acc_b0_d = 1'b0;
                        state_d  = S_MUL;
                     end
                     OP_DIV: begin
                        if (b_in == '0) begin
                           result_d = {a_in, {WIDTH{1'b1}}};
                           dbz_d    = 1'b1;
                           state_d  = S_FIN;
                        end else begin
                           acc_hi_d = '0;
                           acc_lo_d = a_mag;
                           state_d  = S_DIV;
                        end
                     end
                     OP_NOP:  state_d = S_FIN;
                     default: begin
                        result_d = {{WIDTH{1'b0}}, alu_lo};
                        state_d  = S_FIN;
                     end
                  endcase
               end
            end
         end
         S_MUL: begin
            acc_hi_d = booth_hi;
            acc_lo_d = booth_lo;
            acc_b0_d = acc_lo_q[0];
            cnt_d    = cnt_q - (SHW+1)'(1);
            if (cnt_q == (SHW+1)'(1)) begin
               result_d = {booth_hi[WIDTH-1:0], booth_lo};
               state_d  = S_FIN;
            end
         end
         S_DIV: begin
            cnt_d = cnt_q - (SHW+1)'(1);
            if (div_diff[WIDTH]) begin
               acc_hi_d = div_shift;
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_hi_d = div_diff;
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end
            if (cnt_q == (SHW+1)'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = {rem_fix, quo_fix};
            state_d  = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         acc_b0_q <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         acc_b0_q <= acc_b0_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
   assign done        = (state_q == S_FIN);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule
